packed_fifo_reader: RTL and testbench



---
 rtl/packed_fifo_reader_pkg.sv | 14 +
 rtl/packed_fifo_reader_arb.sv | 43 ++++
 rtl/packed_fifo_reader.sv | 126 ++++++++++++
 tb/tb_packed_fifo_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packed_fifo_reader_pkg.sv
// Shared constants and buffer entry type for the packed FIFO drain path.
package packed_fifo_reader_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int STAT_W    = 16;
  localparam int DEF_LOGN  = 2;
  localparam int DEF_WIDTH = 36;

  typedef struct packed {
    logic [DEF_LOGN-1:0]  qid;
    logic [DEF_WIDTH-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/packed_fifo_reader_arb.sv
// rr_arbiter_N: round-robin arbiter; search starts at the pointer, which moves past each grant.
// SIZE must be a power of two (>= 2) so the search index wraps naturally.
module rr_arbiter_N
  import packed_fifo_reader_pkg::*;
#(
  parameter  int SIZE = 4,
  localparam int ID_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SIZE-1:0] req,
  input  logic            advance,
  output logic [SIZE-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  logic [ID_W-1:0] ptr;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      logic [ID_W-1:0] idx;
      idx = ptr + ID_W'(k);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_id   = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/packed_fifo_reader.sv
// packed_fifo_reader: round-robin drain of a packed multi-queue FIFO into a 2-deep valid/ready stream.
// Define PACKED_FIFO_READER_STATS_EN to add per-queue saturating read counters on read_count.
module packed_fifo_reader
  import packed_fifo_reader_pkg::*;
#(
  parameter  int logN  = 2,
  parameter  int WIDTH = 36,
  localparam int N     = 1 << logN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         has_data,
  input  logic [N*WIDTH-1:0]   fifo_data,
  input  logic [N-1:0]         queue_mask,
  output logic                 read,
  output logic [logN-1:0]      rid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [logN-1:0]      out_qid,
  output logic                 idle
`ifdef PACKED_FIFO_READER_STATS_EN
  ,
  output logic [N*STAT_W-1:0]  read_count
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  // Same layout as buf_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [logN-1:0]  qid;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [logN-1:0]  grant_id;
  logic             any;
  logic             pop;
  logic             issue;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after_pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [N-1:0]     sel_p1;
  logic [WIDTH-1:0] cap_word;
  logic [WIDTH-1:0] head_word [N];
  entry_t           buf_q [BUF_DEPTH];

  for (genvar i = 0; i < N; i++) begin : g_head
    assign head_word[i] = fifo_data[i*WIDTH +: WIDTH];
  end

  assign req             = has_data & queue_mask;
  assign pop             = out_valid & out_ready;
  assign count_after_pop = count - CNT_W'(pop);
  // A visible read makes the following cycle the FIFO's busy gap, so a new issue waits one cycle.
  assign issue           = ~read & (count_after_pop < CNT_W'(BUF_DEPTH)) & any;

  rr_arbiter_N #(.SIZE(N)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .advance  (issue),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  always_comb begin
    cap_word = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_p1[i]) cap_word |= head_word[i];
    end
  end

  // ---- stage p0 -> p1: arbitration registers read/rid; p1 -> buffer: capture popped head ----
  always_ff @(posedge clock) begin
    if (reset) begin
      read   <= 1'b0;
      rid    <= '0;
      sel_p1 <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      read   <= issue;
      sel_p1 <= issue ? grant : '0;
      if (issue) rid <= grant_id;
      if (read) begin
        buf_q[wr_ptr] <= entry_t'{qid: rid, data: cap_word};
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(read) - CNT_W'(pop);
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = buf_q[rd_ptr].data;
  assign out_qid   = buf_q[rd_ptr].qid;
  assign idle      = (count == '0) && (req == '0);

`ifdef PACKED_FIFO_READER_STATS_EN
  logic [STAT_W-1:0] stat_cnt [N];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset) stat_cnt[i] <= '0;
      else if (sel_p1[i]) stat_cnt[i] <= sat_inc(stat_cnt[i]);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_stat
    assign read_count[i*STAT_W +: STAT_W] = stat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_packed_fifo_reader.sv
// Self-checking bench for packed_fifo_reader: directed scenarios plus a randomized run against a queue-based model.
module tb_packed_fifo_reader;

  localparam int LOGN = 2;
  localparam int N    = 1 << LOGN;
  localparam int W    = 36;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      has_data = '0;
  logic [N*W-1:0]    fifo_data = '0;
  logic [N-1:0]      queue_mask = '1;
  logic              read;
  logic [LOGN-1:0]   rid;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [LOGN-1:0]   out_qid;
  logic              idle;
`ifdef PACKED_FIFO_READER_STATS_EN
  logic [N*16-1:0]   read_count;
`endif

  packed_fifo_reader #(.logN(LOGN), .WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .has_data   (has_data),
    .fifo_data  (fifo_data),
    .queue_mask (queue_mask),
    .read       (read),
    .rid        (rid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_qid    (out_qid),
    .idle       (idle)
`ifdef PACKED_FIFO_READER_STATS_EN
    ,
    .read_count (read_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Source FIFO contents per queue and reference model state.
  logic [W-1:0] src [N][$];
  typedef struct { int qid; logic [W-1:0] data; } ent_t;
  ent_t        m_buf [$];
  int          m_ptr;
  bit          m_read;
  int          m_rid;
  logic [15:0] m_cnt [N];

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      has_data[i] = (src[i].size() > 0);
      fifo_data[i*W +: W] = (src[i].size() > 0) ? src[i][0] : '0;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) src[i].delete();
    drive_src();
  endtask

  task automatic fill(input int per_q);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < per_q; j++) src[i].push_back(W'({$urandom(), $urandom()}));
    drive_src();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_ptr = 0; m_read = 0; m_rid = 0; m_buf.delete();
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  // One clock: the model decides from the inputs seen at the edge, then the source FIFOs pop on the DUT's read.
  task automatic tick();
    bit pop, push, found, issue, dr;
    int g, drid;
    logic [W-1:0] cap;
    ent_t e;
    pop   = (m_buf.size() != 0) && out_ready;
    push  = m_read;
    cap   = fifo_data[m_rid*W +: W];
    found = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (!found && has_data[i] && queue_mask[i]) begin found = 1; g = i; end
    end
    issue = !m_read && ((int'(m_buf.size()) - int'(pop)) < 2) && found;
    dr = read; drid = int'(rid);
    @(posedge clock); #1;
    if (pop) void'(m_buf.pop_front());
    if (push) begin
      e.qid = m_rid; e.data = cap; m_buf.push_back(e);
      if (m_cnt[m_rid] != 16'hFFFF) m_cnt[m_rid] = m_cnt[m_rid] + 16'd1;
    end
    m_read = issue;
    if (issue) begin m_rid = g; m_ptr = (g + 1) % N; end
    if (dr && src[drid].size() > 0) void'(src[drid].pop_front());
    drive_src();
  endtask

  task automatic test_reset();
    clear_src(); queue_mask = '1; out_ready = 1'b0;
    apply_reset();
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read got=%0b want=0", read); end
    checks++; if (rid !== '0) begin errors++; $display("FAIL reset_rid got=%0d want=0", rid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++; if (out_data !== '0 || out_qid !== '0) begin errors++; $display("FAIL reset_out got=%h/%0d want=0/0", out_data, out_qid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b want=1", idle); end
    src[1].push_back(36'h123); queue_mask = 4'b0000; drive_src(); #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_masked got=%0b want=1", idle); end
    queue_mask = 4'b1111; #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL idle_req got=%0b want=0", idle); end
    queue_mask = 4'b0000; clear_src(); #1;
  endtask

  task automatic test_single_queue();
    clear_src(); queue_mask = '1; out_ready = 1'b1;
    apply_reset();
    src[2].push_back(36'h0_0000_00AB); drive_src();
    tick();
    checks++; if (read !== 1'b1 || rid !== 2'd2) begin errors++; $display("FAIL single_issue got read=%0b rid=%0d want 1/2", read, rid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0b want=0", out_valid); end
    tick();
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL single_gap got=%0b want=0", read); end
    checks++; if (out_valid !== 1'b1 || out_data !== 36'h0AB || out_qid !== 2'd2) begin
      errors++; $display("FAIL single_out got v=%0b d=%h q=%0d want 1/0ab/2", out_valid, out_data, out_qid); end
    tick();
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || read !== 1'b0) begin
      errors++; $display("FAIL single_drained got v=%0b idle=%0b read=%0b want 0/1/0", out_valid, idle, read); end
  endtask

  task automatic test_round_robin();
    int seq [$];
    bit prev;
    clear_src(); queue_mask = '1; out_ready = 1'b1;
    apply_reset();
    fill(3);
    prev = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (read) seq.push_back(int'(rid));
      checks++; if (prev && read) begin errors++; $display("FAIL rr_back_to_back c=%0d got=1 want=0", c); end
      prev = read;
      if (m_buf.size() != 0) begin
        checks++; if (out_data !== m_buf[0].data || out_qid !== LOGN'(m_buf[0].qid)) begin
          errors++; $display("FAIL rr_out c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_qid, m_buf[0].data, m_buf[0].qid); end
      end
    end
    checks++;
    if (seq.size() < 5) begin errors++; $display("FAIL rr_count got=%0d want>=5", seq.size()); end
    else for (int k = 0; k < 5; k++)
      if (seq[k] != k % 4) begin errors++; $display("FAIL rr_seq k=%0d got=%0d want=%0d", k, seq[k], k % 4); end
  endtask

  task automatic test_backpressure();
    int n;
    int got [$];
    clear_src(); queue_mask = '1; out_ready = 1'b0;
    apply_reset();
    fill(3);
    n = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (read) n++; end
    checks++; if (n != 2) begin errors++; $display("FAIL bp_reads got=%0d want=2", n); end
    checks++; if (read !== 1'b0 || out_valid !== 1'b1 || out_qid !== 2'd0) begin
      errors++; $display("FAIL bp_hold got read=%0b v=%0b q=%0d want 0/1/0", read, out_valid, out_qid); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) got.push_back(int'(out_qid));
      tick();
      checks++; if (out_valid !== (m_buf.size() != 0) || read !== m_read) begin
        errors++; $display("FAIL bp_drain c=%0d got v=%0b r=%0b want v=%0b r=%0b", c, out_valid, read, m_buf.size() != 0, m_read); end
    end
    checks++;
    if (got.size() < 6) begin errors++; $display("FAIL bp_drain_count got=%0d want>=6", got.size()); end
    else for (int k = 0; k < 6; k++)
      if (got[k] != k % 4) begin errors++; $display("FAIL bp_order k=%0d got=%0d want=%0d", k, got[k], k % 4); end
  endtask

  task automatic test_mask();
    int seq [$];
    clear_src(); queue_mask = 4'b1010; out_ready = 1'b1;
    apply_reset();
    fill(4);
    for (int c = 0; c < 16; c++) begin tick(); if (read) seq.push_back(int'(rid)); end
    checks++;
    if (seq.size() < 6) begin errors++; $display("FAIL mask_count got=%0d want>=6", seq.size()); end
    else for (int k = 0; k < seq.size(); k++)
      if (seq[k] != ((k % 2) ? 3 : 1)) begin errors++; $display("FAIL mask_seq k=%0d got=%0d want=%0d", k, seq[k], (k % 2) ? 3 : 1); end
    queue_mask = '1;
  endtask

  task automatic test_push_pop();
    clear_src(); queue_mask = '1; out_ready = 1'b0;
    apply_reset();
    src[0].push_back(36'hA0); src[1].push_back(36'hA1); src[2].push_back(36'hA2); drive_src();
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_qid !== 2'd0) begin errors++; $display("FAIL pp_first got v=%0b q=%0d want 1/0", out_valid, out_qid); end
    tick();
    checks++; if (read !== 1'b1 || rid !== 2'd1 || out_qid !== 2'd0) begin
      errors++; $display("FAIL pp_issue got r=%0b rid=%0d q=%0d want 1/1/0", read, rid, out_qid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_qid !== 2'd1 || out_data !== 36'hA1) begin
      errors++; $display("FAIL pp_swap got v=%0b q=%0d d=%h want 1/1/a1", out_valid, out_qid, out_data); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_qid !== 2'd2 || out_data !== 36'hA2) begin
      errors++; $display("FAIL pp_third got v=%0b q=%0d d=%h want 1/2/a2", out_valid, out_qid, out_data); end
  endtask

  task automatic test_reset_midop();
    clear_src(); queue_mask = '1; out_ready = 1'b0;
    apply_reset();
    fill(3);
    for (int c = 0; c < 8; c++) tick();
    checks++; if (out_valid !== 1'b1 || m_buf.size() != 2) begin errors++; $display("FAIL midop_full got v=%0b want 1 (model %0d)", out_valid, m_buf.size()); end
    apply_reset();
    checks++; if (out_valid !== 1'b0 || read !== 1'b0) begin errors++; $display("FAIL midop_flush got v=%0b r=%0b want 0/0", out_valid, read); end
    tick();
    checks++; if (read !== 1'b1 || rid !== 2'd0) begin errors++; $display("FAIL midop_first got r=%0b rid=%0d want 1/0", read, rid); end
  endtask

  task automatic test_random();
    bit exp_idle;
    clear_src(); queue_mask = '1; out_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0) src[$urandom_range(0, N-1)].push_back(W'({$urandom(), $urandom()}));
      if ($urandom_range(0, 15) == 0) queue_mask = N'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      drive_src();
      tick();
      checks++; if (read !== m_read) begin errors++; $display("FAIL rnd_read c=%0d got=%0b want=%0b", c, read, m_read); end
      if (m_read) begin
        checks++; if (rid !== LOGN'(m_rid)) begin errors++; $display("FAIL rnd_rid c=%0d got=%0d want=%0d", c, rid, m_rid); end
      end
      checks++; if (out_valid !== (m_buf.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, out_valid, m_buf.size() != 0); end
      if (m_buf.size() != 0) begin
        checks++; if (out_data !== m_buf[0].data || out_qid !== LOGN'(m_buf[0].qid)) begin
          errors++; $display("FAIL rnd_out c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_qid, m_buf[0].data, m_buf[0].qid); end
      end
      exp_idle = (m_buf.size() == 0) && ((has_data & queue_mask) == '0);
      checks++; if (idle !== exp_idle) begin errors++; $display("FAIL rnd_idle c=%0d got=%0b want=%0b", c, idle, exp_idle); end
    end
`ifdef PACKED_FIFO_READER_STATS_EN
    for (int i = 0; i < N; i++) begin
      checks++; if (read_count[i*16 +: 16] !== m_cnt[i]) begin
        errors++; $display("FAIL stats q=%0d got=%0d want=%0d", i, read_count[i*16 +: 16], m_cnt[i]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_queue();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_push_pop();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
